// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Purpose:
//   In-order store queue between the store reservation station and data
//   memory. An issued store brings its address and a source register index.
//   The register file is read in the same cycle and the {address, data} pair
//   is queued. Queued stores drain to memory one at a time over a
//   valid/ack write port. Issue is therefore decoupled from memory latency.
//
// Optional feature macro:
//   STORE_FWD_EN - when defined, a combinational store-to-load forwarding
//                  lookup runs on ld_addr and returns the youngest matching
//                  queued store. When undefined, fwd_hit/fwd_data are tied to 0.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   AW     memory address width
//   DW     data / register width
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready  store request handshake (ready = not full)
//   req_addr, req_reg    store address and data source register index
//   rf_rd_sel/rf_rd_data register-file read port (same-cycle data)
//   mem_we/mem_addr/mem_wdata/mem_ack  registered memory write port
//   ld_addr, fwd_hit, fwd_data         load forwarding lookup
//   count, empty         occupancy status
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [AW-1:0]              req_addr,
    input  logic [2:0]                 req_reg,
    output logic [2:0]                 rf_rd_sel,
    input  logic [DW-1:0]              rf_rd_data,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic                       mem_ack,
    input  logic [AW-1:0]              ld_addr,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Queue storage
    logic [AW-1:0]    addr_q  [DEPTH];
    logic [AW-1:0]    addr_d  [DEPTH];
    logic [DW-1:0]    data_q  [DEPTH];
    logic [DW-1:0]    data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    // Write-port FSM and registered outputs
    state_t           state_q, state_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;

    logic             push;
    logic             pop;
    logic [PW-1:0]    next_head;

    assign req_ready = (count_q != CW'(DEPTH));
    assign rf_rd_sel = req_reg;
    assign push      = req_valid && req_ready;
    // The head only leaves once memory has acknowledged it; ack in IDLE is ignored.
    assign pop       = (state_q == ST_WRITE) && mem_ack;
    assign next_head = head_q + PW'(1);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);

    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (push) begin
            addr_d[tail_q]  = req_addr;
            data_d[tail_q]  = rf_rd_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = next_head;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[head_q];
                    mem_wdata_d = data_q[head_q];
                end
            end
            ST_WRITE: begin
                // Outputs hold until acked. On ack, the next head is loaded
                // directly. If only the acked entry was queued, the survivor
                // can only be the store pushed this same cycle. Its slot is
                // not written yet, so take it straight from the request path.
                if (pop) begin
                    if (count_d != '0) begin
                        if (count_q == CW'(1)) begin
                            mem_addr_d  = req_addr;
                            mem_wdata_d = rf_rd_data;
                        end else begin
                            mem_addr_d  = addr_q[next_head];
                            mem_wdata_d = data_q[next_head];
                        end
                    end else begin
                        state_d  = ST_IDLE;
                        mem_we_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef STORE_FWD_EN
    // age_hit[k] flags a match in the k-th oldest slot, counted from the head.
    // The in-flight head is included because memory may not have taken it yet.
    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] age_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd_cmp
        assign age_idx[gi] = head_q + PW'(gi);
        assign age_hit[gi] = valid_q[age_idx[gi]] && (addr_q[age_idx[gi]] == ld_addr);
    end

    // Scanning from oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_hit[k]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[age_idx[k]];
            end
        end
    end
`else
    logic [AW-1:0] unused_ld_addr;
    assign unused_ld_addr = ld_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//
// Purpose:
//   Self-checking bench for store_buffer. A tracker process predicts
//   acceptance, occupancy and write-port activity. Accepted stores go into an
//   expected-write queue. A monitor compares the DUT against that queue on
//   every falling edge and pops an entry when the DUT's write is acked.
//   Stimulus is directed first, then randomized.
// -----------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_reg;
    logic [2:0]    rf_rd_sel;
    logic [DW-1:0] rf_rd_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [AW-1:0] ld_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [CW-1:0] count;
    logic          empty;

    always #5 clock = ~clock;

    // Behavioural register file
    logic [DW-1:0] rf [8];
    assign rf_rd_data = rf[rf_rd_sel];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_reg    (req_reg),
        .rf_rd_sel  (rf_rd_sel),
        .rf_rd_data (rf_rd_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .ld_addr    (ld_addr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .count      (count),
        .empty      (empty)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    st_t exp_q[$];          // stores held in the buffer, oldest first
    int  count_m  = 0;      // predicted occupancy
    bit  we_m     = 1'b0;   // predicted mem_we
    bit  last_acc = 1'b0;   // request accepted at the most recent edge

    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void exp_fwd(input logic [AW-1:0] la, output bit h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
`ifdef STORE_FWD_EN
        foreach (exp_q[i]) begin
            if (exp_q[i].a == la) begin
                h = 1'b1;
                d = exp_q[i].d;
            end
        end
`endif
    endfunction

    // ---------------- tracker: acceptance, occupancy, write-port prediction
    bit  trk_push, trk_pop, trk_pw;
    int  trk_cb;
    st_t trk_e;

    initial begin
        forever begin
            @(negedge clock);
            trk_cb   = count_m;
            trk_pw   = we_m;
            trk_push = reset_n && req_valid && (count_m != DEPTH);
            trk_pop  = reset_n && we_m && mem_ack;
            trk_e.a  = req_addr;
            trk_e.d  = rf[req_reg];
            last_acc = trk_push;
            @(posedge clock);
            if (reset_n) begin
                if (trk_push) exp_q.push_back(trk_e);
                count_m = trk_cb + int'(trk_push) - int'(trk_pop);
                // A write stays up while unacked or while anything remains.
                // From idle, a write starts when the buffer was non-empty at the edge.
                we_m = trk_pw ? (!trk_pop || count_m != 0) : (trk_cb != 0);
            end
        end
    end

    // ---------------- monitor: compare DUT against the scoreboard
    bit            mon_h;
    logic [DW-1:0] mon_d;

    initial begin
        forever begin
            @(negedge clock);
            chk("count", 32'(count), 32'(count_m));
            chk("req_ready", 32'(req_ready), 32'(count_m != DEPTH));
            chk("empty", 32'(empty), 32'(count_m == 0));
            chk("mem_we", 32'(mem_we), 32'(we_m));
            exp_fwd(ld_addr, mon_h, mon_d);
            chk("fwd_hit", 32'(fwd_hit), 32'(mon_h));
            chk("fwd_data", 32'(fwd_data), 32'(mon_d));
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
                end else begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].a));
                    chk("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].d));
                    if (mem_ack) begin
                        $display("write acked addr=0x%04h data=0x%04h", mem_addr, mem_wdata);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (all entered at posedge + 1)
    task automatic push_store(input logic [AW-1:0] a, input logic [2:0] r);
        int n = 0;
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_reg   = r;
        do begin
            @(negedge clock);
            acc = (count_m != DEPTH);
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("push_timeout", 32'(acc), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        mem_ack = 1'b1;
        while ((count_m != 0 || we_m) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drain_done", 32'(count_m), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus
    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_reg   = '0;
        mem_ack   = 1'b0;
        ld_addr   = '0;
        for (int i = 0; i < 8; i++) rf[i] = DW'($urandom);

        repeat (3) @(posedge clock);
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single store, ack held high: write appears one cycle after the push.
        rf[3]   = 16'hBEEF;
        mem_ack = 1'b1;
        push_store(16'h0040, 3'd3);
        chk("t1_we_push_cycle", 32'(mem_we), 32'd0);
        @(posedge clock);
        #1;
        chk("t1_we", 32'(mem_we), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h0040);
        chk("t1_data", 32'(mem_wdata), 32'hBEEF);
        @(posedge clock);
        #1;
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_we_off", 32'(mem_we), 32'd0);

        // Fill with ack stalled; the fifth request is held; outputs stay stable.
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) push_store(16'h0100 + 16'(i * 4), 3'(i + 4));
        req_valid = 1'b1;
        req_addr  = 16'h0200;
        req_reg   = 3'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            chk("full_ready", 32'(req_ready), 32'd0);
            chk("full_count", 32'(count), 32'd4);
            chk("stall_addr", 32'(mem_addr), 32'h0100);
            chk("stall_data", 32'(mem_wdata), 32'(rf[4]));
        end
        mem_ack = 1'b1;
        begin
            int n = 0;
            do begin
                @(posedge clock);
                #1;
                n++;
            end while (!last_acc && n < 20);
            chk("held_req_accepted", 32'(last_acc), 32'd1);
        end
        req_valid = 1'b0;
        drain();

        // Forwarding: youngest of two same-address stores wins.
        mem_ack = 1'b0;
        rf[1]   = 16'h1111;
        rf[2]   = 16'h2222;
        push_store(16'h0010, 3'd1);
        push_store(16'h0010, 3'd2);
        ld_addr = 16'h0010;
        #1;
`ifdef STORE_FWD_EN
        chk("fwd_dir_hit", 32'(fwd_hit), 32'd1);
        chk("fwd_dir_data", 32'(fwd_data), 32'h2222);
`else
        chk("fwd_dir_hit", 32'(fwd_hit), 32'd0);
        chk("fwd_dir_data", 32'(fwd_data), 32'd0);
`endif
        ld_addr = 16'h0011;
        #1;
        chk("fwd_dir_miss", 32'(fwd_hit), 32'd0);
        drain();

        // Six back-to-back stores drained continuously: pointers wrap.
        mem_ack = 1'b1;
        for (int i = 0; i < 6; i++) push_store(16'h0300 + 16'(i), 3'($urandom_range(0, 7)));
        drain();

        // Reset during an active write with three entries queued.
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) push_store(16'h0400 + 16'(i), 3'(i));
        @(posedge clock);
        #1;
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        count_m = 0;
        we_m    = 1'b0;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_data", 32'(mem_wdata), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        mem_ack = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("post_rst_no_write", 32'(mem_we), 32'd0);
        end

        // Randomized traffic over a small address set to exercise forwarding.
        for (int c = 0; c < 400; c++) begin
            if (!(req_valid && !last_acc)) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_addr  = 16'h0020 + 16'($urandom_range(0, 5) * 2);
                req_reg   = 3'($urandom_range(0, 7));
            end
            mem_ack = ($urandom_range(0, 2) != 0);
            ld_addr = 16'h0020 + 16'($urandom_range(0, 5) * 2);
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 7)] = DW'($urandom);
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        drain();
        repeat (2) @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
